// File: rtl/candidate_scanner.sv
// Scans the 8x8 grid (coordinates 1..8) one point per cycle against three latched circles
// and counts the points that satisfy the selected set operation; reports with a valid pulse.
module candidate_scanner (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] reg_mode,
    input  logic [3:0] center_x0,
    input  logic [3:0] center_y0,
    input  logic [3:0] center_r0,
    input  logic [3:0] center_x1,
    input  logic [3:0] center_y1,
    input  logic [3:0] center_r1,
    input  logic [3:0] center_x2,
    input  logic [3:0] center_y2,
    input  logic [3:0] center_r2,
    output logic       busy,
    output logic       valid,
    output logic [6:0] candidate
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [1:0] r_mode;
    logic [3:0] r_cx [3];
    logic [3:0] r_cy [3];
    logic [3:0] r_cr [3];
    logic [3:0] w_cx_in [3];
    logic [3:0] w_cy_in [3];
    logic [3:0] w_cr_in [3];
    logic [2:0] w_in;
    logic       w_hit;
    logic       w_start;
    logic       w_last;
    logic       r_busy;
    logic       r_valid;
    logic [6:0] r_candidate;

    assign w_cx_in[0] = center_x0;
    assign w_cy_in[0] = center_y0;
    assign w_cr_in[0] = center_r0;
    assign w_cx_in[1] = center_x1;
    assign w_cy_in[1] = center_y1;
    assign w_cr_in[1] = center_r1;
    assign w_cx_in[2] = center_x2;
    assign w_cy_in[2] = center_y2;
    assign w_cr_in[2] = center_r2;

    // Magnitude of each coordinate difference is squared at full width (<=225), sum kept at 9 bits.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_circle
            logic [3:0] w_dx;
            logic [3:0] w_dy;
            logic [7:0] w_dx2;
            logic [7:0] w_dy2;
            logic [7:0] w_r2;
            logic [8:0] w_dist2;

            always_comb begin
                w_dx    = (r_x >= r_cx[gi]) ? (r_x - r_cx[gi]) : (r_cx[gi] - r_x);
                w_dy    = (r_y >= r_cy[gi]) ? (r_y - r_cy[gi]) : (r_cy[gi] - r_y);
                w_dx2   = {4'd0, w_dx} * {4'd0, w_dx};
                w_dy2   = {4'd0, w_dy} * {4'd0, w_dy};
                w_r2    = {4'd0, r_cr[gi]} * {4'd0, r_cr[gi]};
                w_dist2 = {1'b0, w_dx2} + {1'b0, w_dy2};
            end

            assign w_in[gi] = (w_dist2 <= {1'b0, w_r2});
        end
    endgenerate

    always_comb begin
        case (r_mode)
            2'b00:   w_hit = w_in[0];
            2'b01:   w_hit = w_in[0] & w_in[1];
            2'b10:   w_hit = w_in[0] ^ w_in[1];
            default: w_hit = (w_in == 3'b011) || (w_in == 3'b101) || (w_in == 3'b110);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_next = S_SCAN;
            S_SCAN:  if ((r_x == 4'd8) && (r_y == 4'd8)) w_state_next = S_DONE;
            S_DONE:  w_state_next = en ? S_SCAN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // DONE accepts a start just like IDLE, which gives back-to-back scans every 65 cycles.
    always_comb begin
        w_start = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_start = en;
            S_SCAN:         w_last  = (r_x == 4'd8) && (r_y == 4'd8);
            default:        ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= 4'd1;
            r_y         <= 4'd1;
            r_mode      <= 2'b00;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_candidate <= 7'd0;
            for (int k = 0; k < 3; k++) begin
                r_cx[k] <= 4'd0;
                r_cy[k] <= 4'd0;
                r_cr[k] <= 4'd0;
            end
        end else if (w_start) begin
            r_x         <= 4'd1;
            r_y         <= 4'd1;
            r_mode      <= reg_mode;
            r_busy      <= 1'b1;
            r_valid     <= 1'b0;
            r_candidate <= 7'd0;
            for (int k = 0; k < 3; k++) begin
                r_cx[k] <= w_cx_in[k];
                r_cy[k] <= w_cy_in[k];
                r_cr[k] <= w_cr_in[k];
            end
        end else if (r_state == S_SCAN) begin
            r_candidate <= r_candidate + {6'd0, w_hit};
            if (r_x == 4'd8) begin
                r_x <= 4'd1;
                r_y <= (r_y == 4'd8) ? 4'd1 : (r_y + 4'd1);
            end else begin
                r_x <= r_x + 4'd1;
            end
            r_busy  <= ~w_last;
            r_valid <= w_last;
        end else begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    assign busy      = r_busy;
    assign valid     = r_valid;
    assign candidate = r_candidate;

endmodule

// File: tb/tb_candidate_scanner.sv
// Directed bench for candidate_scanner: hand-computed counts, latency, back-to-back and reset abort.
module tb_candidate_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] reg_mode;
    logic [3:0] cx0, cy0, cr0, cx1, cy1, cr1, cx2, cy2, cr2;
    logic       busy;
    logic       valid;
    logic [6:0] candidate;

    int checks = 0;
    int errors = 0;

    candidate_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .reg_mode  (reg_mode),
        .center_x0 (cx0),
        .center_y0 (cy0),
        .center_r0 (cr0),
        .center_x1 (cx1),
        .center_y1 (cy1),
        .center_r1 (cr1),
        .center_x2 (cx2),
        .center_y2 (cy2),
        .center_r2 (cr2),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_circ(input logic [3:0] x0, y0, r0, x1, y1, r1, x2, y2, r2);
        cx0 = x0; cy0 = y0; cr0 = r0;
        cx1 = x1; cy1 = y1; cr1 = r1;
        cx2 = x2; cy2 = y2; cr2 = r2;
    endtask

    // Pulse en, wait (bounded) for valid, then check latency, count and the cycle after.
    task automatic run_scan(input string tag, input logic [1:0] mode, input int exp, input bit perturb);
        int  n;
        bit  seen;
        bit  dropped;
        reg_mode = mode;
        en = 1'b1;
        tick;
        en = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_cand_clear"}, 32'(candidate), 32'd0);
        n = 0;
        seen = 0;
        dropped = 0;
        while (!seen && n < 100) begin
            if (perturb && n == 10) begin
                set_circ(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                         4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                         4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
                reg_mode = ~mode;
                en = 1'b1;
            end
            if (perturb && n == 11) en = 1'b0;
            tick;
            n++;
            if (valid) seen = 1;
            else if (!busy) dropped = 1;
        end
        check({tag, "_busy_held"}, 32'(dropped), 32'd0);
        check({tag, "_latency"}, 32'(n), 32'd64);
        check({tag, "_count"}, 32'(candidate), 32'(exp));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick;
        check({tag, "_valid_drop"}, 32'(valid), 32'd0);
        check({tag, "_count_hold"}, 32'(candidate), 32'(exp));
    endtask

    initial begin
        int  n;
        bit  seen;

        rst_n = 1'b0;
        en = 1'b0;
        reg_mode = 2'b00;
        set_circ(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_cand", 32'(candidate), 32'd0);
        rst_n = 1'b1;
        tick;
        check("idle_busy", 32'(busy), 32'd0);

        set_circ(4, 4, 2, 1, 1, 15, 8, 8, 15);
        run_scan("single_442", 2'b00, 13, 1'b0);

        set_circ(3, 3, 2, 5, 5, 2, 1, 1, 15);
        run_scan("inter", 2'b01, 3, 1'b0);
        run_scan("xor", 2'b10, 20, 1'b0);

        set_circ(2, 2, 1, 3, 2, 1, 8, 8, 1);
        run_scan("two_of_three", 2'b11, 2, 1'b1);

        set_circ(1, 1, 0, 5, 5, 5, 5, 5, 5);
        run_scan("r_zero", 2'b00, 1, 1'b0);

        set_circ(8, 8, 15, 0, 0, 0, 0, 0, 0);
        run_scan("full_grid", 2'b00, 64, 1'b0);

        set_circ(15, 15, 15, 0, 0, 0, 0, 0, 0);
        run_scan("far_center", 2'b00, 32, 1'b0);

        // en held high: scans run back to back, valid every 65 cycles.
        set_circ(4, 4, 2, 0, 0, 0, 0, 0, 0);
        reg_mode = 2'b00;
        en = 1'b1;
        tick;
        n = 0; seen = 0;
        while (!seen && n < 100) begin tick; n++; if (valid) seen = 1; end
        check("b2b_lat1", 32'(n), 32'd64);
        check("b2b_cnt1", 32'(candidate), 32'd13);
        tick;
        check("b2b_valid_drop", 32'(valid), 32'd0);
        check("b2b_restart_busy", 32'(busy), 32'd1);
        check("b2b_restart_cand", 32'(candidate), 32'd0);
        n = 0; seen = 0;
        while (!seen && n < 100) begin tick; n++; if (valid) seen = 1; end
        check("b2b_lat2", 32'(n), 32'd64);
        check("b2b_cnt2", 32'(candidate), 32'd13);
        en = 1'b0;
        tick;
        check("b2b_end_valid", 32'(valid), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Abort a scan with reset at E30.
        set_circ(8, 8, 15, 0, 0, 0, 0, 0, 0);
        reg_mode = 2'b00;
        en = 1'b1;
        tick;
        en = 1'b0;
        repeat (30) tick;
        check("abort_partial", 32'(candidate), 32'd30);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_cand", 32'(candidate), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin tick; if (valid) seen = 1; end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        set_circ(4, 4, 2, 0, 0, 0, 0, 0, 0);
        run_scan("after_abort", 2'b00, 13, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
